// File: rtl/pc_next_unit_pkg.sv
// Shared constants and types for the program-counter stage.
// Holds the FSM state encoding, the sequential PC increment and the ra index.
package pc_next_unit_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } pc_state_e;

    // Sequential fetch step in bytes (one 32-bit word).
    localparam int unsigned PC_INC = 4;

    // Return-address register (r31), used by the register-file write mux.
    localparam logic [4:0] RA_IDX = 5'd31;

    // Next-PC source, in decreasing priority order.
    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_REG   = 3'd1,
        SEL_LONG  = 3'd2,
        SEL_SHORT = 3'd3,
        SEL_SEQ   = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_next_unit_target_adder.sv
// Combinational branch-target adder: sign-extends a word offset, scales it
// by 4 and adds it to pc. Ports: pc, off (signed words) -> target (bytes).
module pc_target_adder #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned OFF_W  = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [OFF_W-1:0]  off,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] off_bytes;

    // Sign-extend to ADDR_W and append two zero bits for the word scaling;
    // the sum wraps modulo 2^ADDR_W.
    assign off_bytes = {{(ADDR_W-OFF_W-2){off[OFF_W-1]}}, off, 2'b00};
    assign target    = pc + off_bytes;

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage with RUN/HALTED FSM, link write and redirect flag.
// Ports: clk, rst (sync active-low), stall, branch/jump/halt requests in;
// registered pc, link_we, link_data, redirect and halted out.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned LONG_OFF_W  = 26,
    parameter int unsigned SHORT_OFF_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   LongBr_out,
    input  logic [LONG_OFF_W-1:0]  long_off,
    input  logic                   link_en,
    input  logic                   short_br_taken,
    input  logic [SHORT_OFF_W-1:0] short_off,
    input  logic                   reg_jump,
    input  logic [ADDR_W-1:0]      reg_target,
    input  logic                   halt,
    output logic [ADDR_W-1:0]      pc,
    output logic                   link_we,
    output logic [ADDR_W-1:0]      link_data,
    output logic                   redirect,
    output logic                   halted
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] link_data_q, link_data_d;
    logic              link_we_q, link_we_d;
    logic              redirect_q, redirect_d;

    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] long_tgt;
    logic [ADDR_W-1:0] short_tgt;
    logic [ADDR_W-1:0] reg_tgt;
    logic              advance;
    pc_sel_e           sel;

    pc_target_adder #(
        .ADDR_W (ADDR_W),
        .OFF_W  (LONG_OFF_W)
    ) u_long_adder (
        .pc     (pc_q),
        .off    (long_off),
        .target (long_tgt)
    );

    pc_target_adder #(
        .ADDR_W (ADDR_W),
        .OFF_W  (SHORT_OFF_W)
    ) u_short_adder (
        .pc     (pc_q),
        .off    (short_off),
        .target (short_tgt)
    );

    assign pc_seq  = pc_q + ADDR_W'(PC_INC);
    assign reg_tgt = {reg_target[ADDR_W-1:2], 2'b00};
    assign advance = (state_q == ST_RUN) && !stall;

    // Requests may arrive together; the highest one wins and the rest are
    // dropped. Halt keeps the current pc.
    always_comb begin
        sel = SEL_HOLD;
        if (advance) begin
            priority case (1'b1)
                halt:           sel = SEL_HOLD;
                reg_jump:       sel = SEL_REG;
                LongBr_out:     sel = SEL_LONG;
                short_br_taken: sel = SEL_SHORT;
                default:        sel = SEL_SEQ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        link_data_d = link_data_q;
        link_we_d   = 1'b0;
        redirect_d  = 1'b0;

        if (advance && halt) begin
            state_d = ST_HALTED;
        end

        unique case (sel)
            SEL_REG: begin
                pc_d       = reg_tgt;
                redirect_d = 1'b1;
            end
            SEL_LONG: begin
                pc_d       = long_tgt;
                redirect_d = 1'b1;
                // bl only links when its own branch is the one taken.
                if (link_en) begin
                    link_we_d   = 1'b1;
                    link_data_d = pc_seq;
                end
            end
            SEL_SHORT: begin
                pc_d       = short_tgt;
                redirect_d = 1'b1;
            end
            SEL_SEQ: begin
                pc_d = pc_seq;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC[ADDR_W-1:0];
            link_data_q <= '0;
            link_we_q   <= 1'b0;
            redirect_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            link_data_q <= link_data_d;
            link_we_q   <= link_we_d;
            redirect_q  <= redirect_d;
        end
    end

    assign pc        = pc_q;
    assign link_we   = link_we_q;
    assign link_data = link_data_q;
    assign redirect  = redirect_q;
    assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed-vector bench for pc_next_unit.
// Drives requests after each rising edge and checks registered outputs.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        LongBr_out;
    logic [25:0] long_off;
    logic        link_en;
    logic        short_br_taken;
    logic [15:0] short_off;
    logic        reg_jump;
    logic [31:0] reg_target;
    logic        halt;
    logic [31:0] pc;
    logic        link_we;
    logic [31:0] link_data;
    logic        redirect;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_next_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .LongBr_out     (LongBr_out),
        .long_off       (long_off),
        .link_en        (link_en),
        .short_br_taken (short_br_taken),
        .short_off      (short_off),
        .reg_jump       (reg_jump),
        .reg_target     (reg_target),
        .halt           (halt),
        .pc             (pc),
        .link_we        (link_we),
        .link_data      (link_data),
        .redirect       (redirect),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall          = 1'b0;
        LongBr_out     = 1'b0;
        long_off       = '0;
        link_en        = 1'b0;
        short_br_taken = 1'b0;
        short_off      = '0;
        reg_jump       = 1'b0;
        reg_target     = '0;
        halt           = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] t);
        idle();
        reg_jump   = 1'b1;
        reg_target = t;
        step();
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_redir", {31'b0, redirect}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_lwe", {31'b0, link_we}, 32'h0);
        chk("rst_ldata", link_data, 32'h0);

        rst = 1'b1;
        step();
        chk("seq_4", pc, 32'h4);
        step();
        chk("seq_8", pc, 32'h8);
        step();
        chk("seq_c", pc, 32'hC);
        chk("seq_redir", {31'b0, redirect}, 32'h0);
        step();
        chk("seq_10", pc, 32'h10);

        // long branch backwards by two words
        LongBr_out = 1'b1;
        long_off   = 26'h3FFFFFE;
        step();
        idle();
        chk("lb_pc", pc, 32'h08);
        chk("lb_redir", {31'b0, redirect}, 32'h1);
        chk("lb_lwe", {31'b0, link_we}, 32'h0);
        step();
        chk("lb_seq", pc, 32'h0C);
        chk("lb_redir_drop", {31'b0, redirect}, 32'h0);

        // bl
        jump_to(32'h20);
        chk("jr_20", pc, 32'h20);
        LongBr_out = 1'b1;
        link_en    = 1'b1;
        long_off   = 26'd5;
        step();
        idle();
        chk("bl_pc", pc, 32'h34);
        chk("bl_lwe", {31'b0, link_we}, 32'h1);
        chk("bl_ldata", link_data, 32'h24);
        step();
        chk("bl_pc2", pc, 32'h38);
        chk("bl_lwe_drop", {31'b0, link_we}, 32'h0);
        chk("bl_ldata_hold", link_data, 32'h24);

        // link_en without taken branch
        jump_to(32'h20);
        link_en  = 1'b1;
        long_off = 26'd5;
        step();
        idle();
        chk("nl_pc", pc, 32'h24);
        chk("nl_lwe", {31'b0, link_we}, 32'h0);

        // priority: register jump beats both branches and the link
        reg_jump       = 1'b1;
        reg_target     = 32'h103;
        LongBr_out     = 1'b1;
        link_en        = 1'b1;
        long_off       = 26'd5;
        short_br_taken = 1'b1;
        short_off      = 16'd3;
        step();
        chk("pri_pc", pc, 32'h100);
        chk("pri_lwe", {31'b0, link_we}, 32'h0);
        chk("pri_redir", {31'b0, redirect}, 32'h1);
        stall = 1'b1;
        step();
        chk("stl_pc", pc, 32'h100);
        chk("stl_redir", {31'b0, redirect}, 32'h0);
        chk("stl_lwe", {31'b0, link_we}, 32'h0);
        chk("stl_ldata", link_data, 32'h24);
        idle();

        // short branch priority over sequential
        short_br_taken = 1'b1;
        short_off      = 16'hFFFF;
        step();
        idle();
        chk("sb_neg", pc, 32'hFC);
        chk("sb_redir", {31'b0, redirect}, 32'h1);

        // wrap-around
        jump_to(32'hFFFF_FFFC);
        chk("wr_top", pc, 32'hFFFF_FFFC);
        step();
        chk("wr_seq", pc, 32'h0);
        jump_to(32'hFFFF_FFFC);
        short_br_taken = 1'b1;
        short_off      = 16'd1;
        step();
        idle();
        chk("wr_sb", pc, 32'h0);
        chk("wr_sb_redir", {31'b0, redirect}, 32'h1);

        // halt
        jump_to(32'h40);
        halt = 1'b1;
        step();
        idle();
        chk("hlt_pc", pc, 32'h40);
        chk("hlt_flag", {31'b0, halted}, 32'h1);
        chk("hlt_redir", {31'b0, redirect}, 32'h0);
        LongBr_out = 1'b1;
        link_en    = 1'b1;
        long_off   = 26'd7;
        reg_jump   = 1'b1;
        reg_target = 32'h200;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hlt_hold_pc", pc, 32'h40);
            chk("hlt_hold_f", {31'b0, halted}, 32'h1);
            chk("hlt_hold_lwe", {31'b0, link_we}, 32'h0);
        end
        idle();
        rst = 1'b0;
        step();
        chk("hrst_pc", pc, 32'h0);
        chk("hrst_halted", {31'b0, halted}, 32'h0);

        // reset cancels a pending link write and redirect
        rst        = 1'b1;
        LongBr_out = 1'b1;
        link_en    = 1'b1;
        long_off   = 26'd5;
        step();
        chk("bl2_pc", pc, 32'h14);
        chk("bl2_lwe", {31'b0, link_we}, 32'h1);
        chk("bl2_ldata", link_data, 32'h4);
        rst = 1'b0;
        step();
        chk("rc_lwe", {31'b0, link_we}, 32'h0);
        chk("rc_redir", {31'b0, redirect}, 32'h0);
        chk("rc_pc", pc, 32'h0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter stage directly downstream of JumpDecider in the KGP miniRISC datapath.
- Consumes the long-branch decision LongBr_out, the short/register branch requests and the halt request from the decoder, and holds the architectural PC.
- Produces the PC for instruction fetch, the return-address write for `bl`, and a one-cycle redirect indication.
- Contains a RUN/HALTED state machine.

Parameters:
- ADDR_W, 32, PC and target width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- LONG_OFF_W, 26, width of the long-branch word offset (label field of b/bl/bcy/bncy).
- SHORT_OFF_W, 16, width of the short-branch word offset (bltz/bz/bnz).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- stall  in  1  hold all state this cycle; no request is consumed.
- LongBr_out  in  1  taken decision from JumpDecider.
- long_off  in  LONG_OFF_W  signed word offset for a long branch.
- link_en  in  1  current instruction is `bl`.
- short_br_taken  in  1  register-condition branch taken (already evaluated).
- short_off  in  SHORT_OFF_W  signed word offset for a short branch.
- reg_jump  in  1  `br` (jump to register).
- reg_target  in  ADDR_W  register jump target.
- halt  in  1  `halt` instruction.
- pc  out  ADDR_W  current PC to fetch.
- link_we  out  1  one-cycle write strobe for ra (r31).
- link_data  out  ADDR_W  return address (old pc+4).
- redirect  out  1  previous cycle took a non-sequential PC.
- halted  out  1  FSM in HALTED.

Behaviour:
- Reset values:
  - pc = RESET_PC; link_we = 0; link_data = 0; redirect = 0; halted = 0; state = RUN.
  - Reset overrides stall and every request.
- States:
  - RUN -> HALTED when halt==1 and stall==0. pc holds (not advanced).
  - HALTED -> HALTED for every input. Exit only via reset.
  - In HALTED all requests are ignored; pc, link_data and halted hold; link_we and redirect are 0.
- RUN with stall==1:
  - pc, link_data and state hold.
  - link_we = 0 and redirect = 0 next cycle.
- RUN with stall==0, next pc priority (highest first):
  1. halt -> pc
  2. reg_jump -> {reg_target[ADDR_W-1:2], 2'b00}
  3. LongBr_out -> pc + (sext(long_off) << 2)
  4. short_br_taken -> pc + (sext(short_off) << 2)
  5. otherwise -> pc + 4
- Arithmetic is modulo 2^ADDR_W:
  - 32'hFFFF_FFFC + 4 = 0.
  - Negative offsets wrap the same way.
- redirect:
  - Registered, 1-cycle latency.
  - Set to 1 for the cycle after a priority 2, 3 or 4 selection; 0 otherwise.
  - Also set for a taken branch whose target equals pc+4.
- Link write:
  - When link_en==1, LongBr_out==1, stall==0 and state RUN, the next cycle has link_we=1 and link_data = old pc + 4.
  - link_we drops after exactly one cycle.
  - link_en with LongBr_out==0 produces no write.
  - If reg_jump overrides the branch, there is no link write either.
- Simultaneous requests:
  - Resolved strictly by the priority above; lower requests are dropped, not queued.
- Reset mid-operation:
  - A pending link write or redirect is cancelled (both outputs 0 the next cycle).
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package holds:
  - state encoding (ST_RUN=1'b0, ST_HALTED=1'b1);
  - PC_INC=4;
  - the RA register index constant 5'd31, used by the register-file write mux.
- One natural sub-module: pc_target_adder. It is combinational: sign-extend, shift by 2, add to pc. It is instantiated twice, for the long and the short offset.

Test Plan:
- Reset sequencing: rst=0 for 2 cycles, then 1, no requests -> pc = 0, 4, 8, 12; redirect = 0; halted = 0.
- Long branch: at pc=0x10, LongBr_out=1, long_off=26'h3FFFFFE (-2) -> next pc=0x08; redirect=1 for one cycle.
- bl: at pc=0x20, LongBr_out=1, link_en=1, long_off=5 -> pc=0x34; link_we=1 for exactly one cycle with link_data=0x24.
  - Repeat with LongBr_out=0 -> pc=0x24, link_we stays 0.
- Priority and stall:
  - reg_jump=1, reg_target=0x103, LongBr_out=1, short_br_taken=1 -> pc=0x100, no link write.
  - Same inputs with stall=1 -> pc unchanged, redirect=0.
- Wrap-around: pc=0xFFFF_FFFC with no request -> pc=0. A short branch with short_off=1 from 0xFFFF_FFFC -> pc=0.
- Halt: halt=1 at pc=0x40 -> halted=1 next cycle, pc stays 0x40 for 5 cycles despite LongBr_out=1. Then rst=0 -> pc=0, halted=0.
